// File: rtl/sa_sequencer_if.sv
// Handshake and control bundle between the tile sequencer, the AXI-S adapters and the array.
// The sequencer owns the master side; the surrounding logic (or a bench) uses the slave side.
interface sa_sequencer_if #(
    parameter int K_W = 16
);
    logic           s_valid;
    logic           s_ready;
    logic           s_last;
    logic           en;
    logic           zero;
    logic           clr_n;
    logic           m_valid;
    logic           m_ready;
    logic           m_last;
    logic           shift;
    logic           busy;
    logic [K_W-1:0] beats;

    modport master (
        input  s_valid, s_last, m_ready,
        output s_ready, en, zero, clr_n, m_valid, m_last, shift, busy, beats
    );

    modport slave (
        output s_valid, s_last, m_ready,
        input  s_ready, en, zero, clr_n, m_valid, m_last, shift, busy, beats
    );
endinterface

// File: rtl/sa_sequencer.sv
// Tile sequencer for the systolic array: accepts K input beats, flushes the skew lines with
// D zero cycles, then streams R result rows out under valid/ready, clearing the array between tiles.
module sa_sequencer #(
    parameter int R   = 4,
    parameter int C   = 4,
    parameter int L   = 1,
    parameter int K_W = 16
) (
    input  logic            c,
    input  logic            r,
    sa_sequencer_if.master  io
);
    localparam int D  = R + C - 2 + L;
    localparam int DW = (D > 0) ? $clog2(D + 1) : 1;
    localparam int RW = $clog2(R + 1);

    localparam logic [DW-1:0]  DCNT_LOAD = DW'((D > 0) ? D - 1 : 0);
    localparam logic [RW-1:0]  LAST_ROW  = RW'(R - 1);
    localparam logic [K_W-1:0] BEATS_MAX = '1;

    typedef enum logic [2:0] {CLR, IDLE, RUN, DRAIN, OUT} state_t;

    state_t         state, state_nxt;
    logic [DW-1:0]  dcnt, dcnt_nxt;
    logic [RW-1:0]  ocnt, ocnt_nxt;
    logic [K_W-1:0] beats, beats_nxt;
    logic           last_row;

    function automatic logic [K_W-1:0] sat_inc(input logic [K_W-1:0] v);
        return (v == BEATS_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge c) begin
        if (r) begin
            state <= CLR;
            dcnt  <= '0;
            ocnt  <= '0;
            beats <= '0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
            ocnt  <= ocnt_nxt;
            beats <= beats_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        dcnt_nxt   = dcnt;
        ocnt_nxt   = ocnt;
        beats_nxt  = beats;
        last_row   = (ocnt == LAST_ROW);
        io.s_ready = 1'b0;
        io.en      = 1'b0;
        io.zero    = 1'b0;
        io.clr_n   = 1'b1;
        io.m_valid = 1'b0;
        io.m_last  = 1'b0;
        io.shift   = 1'b0;
        io.busy    = 1'b1;

        unique case (state)
            CLR: begin
                io.clr_n  = 1'b0;
                beats_nxt = '0;
                state_nxt = IDLE;
            end
            IDLE, RUN: begin
                // The array only advances on accepted beats; bubbles simply hold it.
                io.s_ready = 1'b1;
                io.en      = io.s_valid;
                io.busy    = (state != IDLE);
                if (io.s_valid) begin
                    beats_nxt = (state == IDLE) ? K_W'(1) : sat_inc(beats);
                    if (io.s_last) begin
                        if (D == 0) begin
                            state_nxt = OUT;
                            ocnt_nxt  = '0;
                        end else begin
                            state_nxt = DRAIN;
                            dcnt_nxt  = DCNT_LOAD;
                        end
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            DRAIN: begin
                io.en   = 1'b1;
                io.zero = 1'b1;
                if (dcnt != '0) begin
                    dcnt_nxt = dcnt - 1'b1;
                end else begin
                    state_nxt = OUT;
                    ocnt_nxt  = '0;
                end
            end
            OUT: begin
                io.m_valid = 1'b1;
                io.m_last  = last_row;
                io.shift   = io.m_ready;
                if (io.m_ready) begin
                    ocnt_nxt = ocnt + 1'b1;
                    if (last_row) state_nxt = CLR;
                end
            end
            default: state_nxt = CLR;
        endcase
    end

    assign io.beats = beats;
endmodule

// File: tb/tb_sa_sequencer.sv
// Bench for sa_sequencer: two instances (R=C=4,L=1 and R=C=1,L=0 with a 3-bit beat counter)
// checked every cycle against a timeline model, plus directed literal expectations.
module tb_sa_sequencer;
    localparam int N = 2;

    logic c = 1'b0;
    always #5 c = ~c;

    logic rs [N];
    logic sv [N];
    logic sl [N];
    logic mr [N];

    logic o_srdy [N];
    logic o_en   [N];
    logic o_zero [N];
    logic o_clrn [N];
    logic o_mv   [N];
    logic o_ml   [N];
    logic o_sh   [N];
    logic o_busy [N];
    int   o_beats[N];

    sa_sequencer_if #(.K_W(16)) bus0 ();
    sa_sequencer_if #(.K_W(3))  bus1 ();

    assign bus0.s_valid = sv[0];
    assign bus0.s_last  = sl[0];
    assign bus0.m_ready = mr[0];
    assign bus1.s_valid = sv[1];
    assign bus1.s_last  = sl[1];
    assign bus1.m_ready = mr[1];

    always_comb begin
        o_srdy[0] = bus0.s_ready; o_en[0] = bus0.en;   o_zero[0] = bus0.zero;
        o_clrn[0] = bus0.clr_n;   o_mv[0] = bus0.m_valid; o_ml[0] = bus0.m_last;
        o_sh[0]   = bus0.shift;   o_busy[0] = bus0.busy;  o_beats[0] = int'(bus0.beats);
        o_srdy[1] = bus1.s_ready; o_en[1] = bus1.en;   o_zero[1] = bus1.zero;
        o_clrn[1] = bus1.clr_n;   o_mv[1] = bus1.m_valid; o_ml[1] = bus1.m_last;
        o_sh[1]   = bus1.shift;   o_busy[1] = bus1.busy;  o_beats[1] = int'(bus1.beats);
    end

    sa_sequencer #(.R(4), .C(4), .L(1), .K_W(16)) dut0 (.c(c), .r(rs[0]), .io(bus0.master));
    sa_sequencer #(.R(1), .C(1), .L(0), .K_W(3))  dut1 (.c(c), .r(rs[1]), .io(bus1.master));

    function automatic int rp(input int i);   return (i == 0) ? 4 : 1;     endfunction
    function automatic int dp(input int i);   return (i == 0) ? 7 : 0;     endfunction
    function automatic int bmax(input int i); return (i == 0) ? 65535 : 7; endfunction

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Timeline model: a tile is described by the cycle of its s_last handshake (tsl),
    // the number of result rows taken so far, and a pending clear cycle.
    bit known   [N];
    bit clr_now [N];
    int tsl     [N];
    int nshift  [N];
    int nbeats  [N];

    int n_en[N], n_zero[N], n_sh[N], n_mlsh[N], n_clr[N], n_mv[N];
    int t_sl[N], t_mv[N], bm[N];
    int pat[5] = '{1, 0, 0, 1, 1};

    task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL d%0d %s cyc=%0d got=%0d expected=%0d", i, nm, cyc, act, exp);
        end
    endtask

    initial forever begin
        @(posedge c);
        for (int i = 0; i < N; i++) begin
            if (rs[i]) begin
                known[i] = 1'b1; clr_now[i] = 1'b1; tsl[i] = -1; nshift[i] = 0; nbeats[i] = 0;
            end else if (!known[i]) begin
                known[i] = 1'b0;
            end else if (clr_now[i]) begin
                clr_now[i] = 1'b0; nbeats[i] = 0;
            end else if (tsl[i] < 0) begin
                if (sv[i]) begin
                    if (nbeats[i] < bmax(i)) nbeats[i]++;
                    if (sl[i]) tsl[i] = cyc;
                end
            end else if (cyc > tsl[i] + dp(i)) begin
                if (mr[i]) begin
                    nshift[i]++;
                    if (nshift[i] == rp(i)) begin
                        clr_now[i] = 1'b1; tsl[i] = -1; nshift[i] = 0;
                    end
                end
            end
        end
        cyc++;
    end

    initial forever begin
        @(negedge c);
        for (int i = 0; i < N; i++) begin
            if (known[i]) begin
                logic e_srdy, e_en, e_zero, e_clrn, e_mv, e_ml, e_sh, e_busy;
                e_srdy = 0; e_en = 0; e_zero = 0; e_clrn = 1; e_mv = 0; e_ml = 0; e_sh = 0; e_busy = 1;
                if (clr_now[i]) begin
                    e_clrn = 0;
                end else if (tsl[i] < 0) begin
                    e_srdy = 1; e_en = sv[i]; e_busy = (nbeats[i] != 0);
                end else if (cyc <= tsl[i] + dp(i)) begin
                    e_en = 1; e_zero = 1;
                end else begin
                    e_mv = 1; e_sh = mr[i]; e_ml = (nshift[i] == rp(i) - 1);
                end
                chk(i, "s_ready", o_srdy[i], e_srdy);
                chk(i, "en", o_en[i], e_en);
                chk(i, "zero", o_zero[i], e_zero);
                chk(i, "clr_n", o_clrn[i], e_clrn);
                chk(i, "m_valid", o_mv[i], e_mv);
                chk(i, "m_last", o_ml[i], e_ml);
                chk(i, "shift", o_sh[i], e_sh);
                chk(i, "busy", o_busy[i], e_busy);
                if (!clr_now[i]) chk(i, "beats", o_beats[i], nbeats[i]);
            end
            if (o_en[i] === 1'b1) n_en[i]++;
            if (o_zero[i] === 1'b1) n_zero[i]++;
            if (o_sh[i] === 1'b1) n_sh[i]++;
            if (o_sh[i] === 1'b1 && o_ml[i] === 1'b1) n_mlsh[i]++;
            if (o_clrn[i] === 1'b0) n_clr[i]++;
            if (o_mv[i] === 1'b1) n_mv[i]++;
            if (sv[i] && sl[i] && o_srdy[i] === 1'b1) begin
                t_sl[i] = cyc; t_mv[i] = -1;
            end else if (o_mv[i] === 1'b1 && t_mv[i] < 0) begin
                t_mv[i] = cyc; bm[i] = o_beats[i];
            end
        end
    end

    task automatic step();
        @(posedge c); #1;
    endtask

    task automatic send_beats(input int i, input int k, input int pv, input int pr, input bit noise);
        int sent = 0;
        int guard = 0;
        while (sent < k && guard < 2000) begin
            guard++;
            sv[i] = ($urandom_range(99) < pv);
            sl[i] = sv[i] ? (sent == k - 1) : (noise && $urandom_range(3) == 0);
            mr[i] = ($urandom_range(99) < pr);
            @(negedge c);
            if (sv[i] && o_srdy[i] === 1'b1) sent++;
            step();
        end
        sv[i] = 0; sl[i] = 0;
        if (sent < k) chk(i, "input_timeout", sent, k);
    endtask

    task automatic wait_idle(input int i, input int pr, input bit noise);
        int guard = 0;
        while (o_busy[i] !== 1'b0 && guard < 2000) begin
            guard++;
            mr[i] = ($urandom_range(99) < pr);
            if (noise) begin
                sv[i] = $urandom_range(1); sl[i] = $urandom_range(1);
            end
            step();
        end
        sv[i] = 0; sl[i] = 0; mr[i] = 0;
        if (o_busy[i] !== 1'b0) chk(i, "idle_timeout", o_busy[i], 0);
    endtask

    task automatic run_tile(input int i, input int k, input int pv, input int pr, input bit noise);
        send_beats(i, k, pv, pr, noise);
        wait_idle(i, pr, noise);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, z0, s0, m0, c0, v0, stall, guard;
        for (int i = 0; i < N; i++) begin
            rs[i] = 1; sv[i] = 0; sl[i] = 0; mr[i] = 0; t_mv[i] = -1; t_sl[i] = -1;
        end

        // Reset held three cycles: one clear cycle, then idle.
        repeat (3) @(posedge c);
        #1; rs[0] = 0; rs[1] = 0;
        @(negedge c);
        chk(0, "t1_clr_n", o_clrn[0], 0);
        chk(0, "t1_busy_clr", o_busy[0], 1);
        @(negedge c);
        chk(0, "t1_s_ready", o_srdy[0], 1);
        chk(0, "t1_busy", o_busy[0], 0);
        step();

        // Five-beat tile, no stalls.
        e0 = n_en[0]; z0 = n_zero[0]; s0 = n_sh[0]; m0 = n_mlsh[0]; c0 = n_clr[0];
        run_tile(0, 5, 100, 100, 0);
        chk(0, "t2_en_cycles", n_en[0] - e0, 12);
        chk(0, "t2_zero_cycles", n_zero[0] - z0, 7);
        chk(0, "t2_shifts", n_sh[0] - s0, 4);
        chk(0, "t2_last_shifts", n_mlsh[0] - m0, 1);
        chk(0, "t2_clr_pulses", n_clr[0] - c0, 1);
        chk(0, "t2_latency", t_mv[0] - t_sl[0], 8);
        chk(0, "t2_beats", bm[0], 5);

        // Input bubbles 1,0,0,1,1(last).
        e0 = n_en[0];
        for (int j = 0; j < 5; j++) begin
            sv[0] = pat[j][0]; sl[0] = (j == 4); mr[0] = 1;
            step();
        end
        sv[0] = 0; sl[0] = 0;
        chk(0, "t3_en_cycles", n_en[0] - e0, 3);
        @(negedge c);
        chk(0, "t3_drain_next", o_zero[0], 1);
        chk(0, "t3_beats", o_beats[0], 3);
        wait_idle(0, 100, 0);

        // Output backpressure: three stall cycles after two rows.
        send_beats(0, 4, 100, 0, 0);
        s0 = n_sh[0]; m0 = n_mlsh[0]; v0 = n_mv[0]; stall = 0; guard = 0;
        while (o_busy[0] !== 1'b0 && guard < 200) begin
            guard++;
            if (n_sh[0] - s0 == 2 && stall < 3 && o_mv[0] === 1'b1) begin
                mr[0] = 0; stall++;
            end else begin
                mr[0] = 1;
            end
            step();
        end
        mr[0] = 0;
        chk(0, "t4_shifts", n_sh[0] - s0, 4);
        chk(0, "t4_last_shifts", n_mlsh[0] - m0, 1);
        chk(0, "t4_valid_cycles", n_mv[0] - v0, 7);
        chk(0, "t4_stalls", stall, 3);

        // Single-beat tiles, including the zero-drain instance.
        s0 = n_sh[0];
        run_tile(0, 1, 100, 100, 0);
        chk(0, "t5_latency", t_mv[0] - t_sl[0], 8);
        chk(0, "t5_beats", bm[0], 1);
        chk(0, "t5_shifts", n_sh[0] - s0, 4);
        s0 = n_sh[1]; m0 = n_mlsh[1]; z0 = n_zero[1];
        run_tile(1, 1, 100, 100, 0);
        chk(1, "t5_latency_d0", t_mv[1] - t_sl[1], 1);
        chk(1, "t5_shifts_d0", n_sh[1] - s0, 1);
        chk(1, "t5_last_d0", n_mlsh[1] - m0, 1);
        chk(1, "t5_zero_d0", n_zero[1] - z0, 0);
        run_tile(1, 10, 100, 100, 0);
        chk(1, "t5_beats_sat", bm[1], 7);

        // Reset during DRAIN, then during OUT, then a normal tile.
        send_beats(0, 3, 100, 100, 0);
        repeat (3) step();
        rs[0] = 1; step(); rs[0] = 0;
        s0 = n_sh[0]; v0 = n_mv[0];
        @(negedge c);
        chk(0, "t6_clr_after_drain", o_clrn[0], 0);
        mr[0] = 1;
        repeat (20) step();
        chk(0, "t6_no_valid_drain", n_mv[0] - v0, 0);
        chk(0, "t6_no_shift_drain", n_sh[0] - s0, 0);
        send_beats(0, 2, 100, 0, 0);
        guard = 0;
        while (o_mv[0] !== 1'b1 && guard < 50) begin guard++; step(); end
        chk(0, "t6_reached_out", o_mv[0], 1);
        rs[0] = 1; step(); rs[0] = 0;
        v0 = n_mv[0];
        @(negedge c);
        chk(0, "t6_clr_after_out", o_clrn[0], 0);
        repeat (15) step();
        chk(0, "t6_no_valid_out", n_mv[0] - v0, 0);
        s0 = n_sh[0];
        run_tile(0, 4, 100, 100, 0);
        chk(0, "t6_next_tile", n_sh[0] - s0, 4);

        // Randomised tiles with bubbles, backpressure, noise and occasional resets.
        for (int t = 0; t < 30; t++) begin
            int k, pv, pr;
            k = $urandom_range(9, 1); pv = $urandom_range(100, 40); pr = $urandom_range(100, 30);
            if ($urandom_range(7) == 0) begin
                send_beats(0, k, pv, pr, 1);
                repeat ($urandom_range(12, 1)) begin mr[0] = $urandom_range(1); step(); end
                rs[0] = 1; step(); rs[0] = 0;
                wait_idle(0, 100, 0);
            end else begin
                run_tile(0, k, pv, pr, 1);
            end
        end
        for (int t = 0; t < 25; t++) begin
            run_tile(1, $urandom_range(12, 1), $urandom_range(100, 40), $urandom_range(100, 30), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
